// File: rtl/axiline_input_loader.sv
// Ping-pong input loader for the Axiline datapath: assembles (x, w) element
// pairs plus a per-sample bias into full vectors and presents each finished
// sample over a valid/ready handshake while the next one fills the other bank.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     element stream handshake (in_ready depends only on state)
//   in_x, in_w            element pair
//   in_bias               sample bias, taken with the first element
//   in_last               final element of a sample
//   out_valid/out_ready   sample handshake
//   data_out_x/_w         assembled vectors, element i at [bitwidth*i +: bitwidth]
//   bias_out              bias of the presented sample
//   err_len               sticky: a sample hit `size` elements without in_last
module axiline_input_loader #(
  parameter int unsigned bitwidth = 8,
  parameter int unsigned size     = 18,
  parameter int unsigned cntWidth = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [bitwidth-1:0]      in_x,
  input  logic [bitwidth-1:0]      in_w,
  input  logic [bitwidth-1:0]      in_bias,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [bitwidth*size-1:0] data_out_x,
  output logic [bitwidth*size-1:0] data_out_w,
  output logic [bitwidth-1:0]      bias_out,
  output logic                     err_len
);

  localparam int unsigned NBANK = 2;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

  bank_state_t               bank_state     [NBANK];
  bank_state_t               bank_state_nxt [NBANK];
  logic                      fill_sel, fill_sel_nxt;
  logic                      pres_sel, pres_sel_nxt;
  logic [cntWidth-1:0]       cnt, cnt_nxt;
  logic                      err_len_nxt;

  logic [bitwidth-1:0]       x_mem    [NBANK][size];
  logic [bitwidth-1:0]       w_mem    [NBANK][size];
  logic [bitwidth-1:0]       bias_mem [NBANK];

  logic                      accept;
  logic                      close;
  logic                      consume;

  // Handshake decodes
  assign in_ready  = (bank_state[fill_sel] != FULL);
  assign out_valid = (bank_state[pres_sel] == FULL);
  assign accept    = in_valid & in_ready;
  assign close     = accept & (in_last | (cnt == cntWidth'(size - 1)));
  assign consume   = out_valid & out_ready;

  // Next-state: fill side and drain side always touch different banks
  always_comb begin
    for (int b = 0; b < NBANK; b++) bank_state_nxt[b] = bank_state[b];
    fill_sel_nxt = fill_sel;
    pres_sel_nxt = pres_sel;
    cnt_nxt      = cnt;
    err_len_nxt  = err_len;

    for (int b = 0; b < NBANK; b++) begin
      if (fill_sel == 1'(b)) begin
        if (close)                          bank_state_nxt[b] = FULL;
        else if (accept && cnt == '0)       bank_state_nxt[b] = FILLING;
      end
      if (consume && pres_sel == 1'(b))     bank_state_nxt[b] = EMPTY;
    end

    if (close) begin
      fill_sel_nxt = ~fill_sel;
      cnt_nxt      = '0;
      if (!in_last) err_len_nxt = 1'b1;
    end else if (accept) begin
      cnt_nxt = cnt + cntWidth'(1);
    end

    if (consume) pres_sel_nxt = ~pres_sel;
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBANK; b++) bank_state[b] <= EMPTY;
      fill_sel <= 1'b0;
      pres_sel <= 1'b0;
      cnt      <= '0;
      err_len  <= 1'b0;
    end else begin
      for (int b = 0; b < NBANK; b++) bank_state[b] <= bank_state_nxt[b];
      fill_sel <= fill_sel_nxt;
      pres_sel <= pres_sel_nxt;
      cnt      <= cnt_nxt;
      err_len  <= err_len_nxt;
    end
  end

  // Bank storage; a short sample zeroes the tail so stale data never leaks out
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBANK; b++) begin
        bias_mem[b] <= '0;
        for (int i = 0; i < size; i++) begin
          x_mem[b][i] <= '0;
          w_mem[b][i] <= '0;
        end
      end
    end else if (accept) begin
      if (cnt == '0) bias_mem[fill_sel] <= in_bias;
      for (int i = 0; i < size; i++) begin
        if (cnt == cntWidth'(i)) begin
          x_mem[fill_sel][i] <= in_x;
          w_mem[fill_sel][i] <= in_w;
        end else if (in_last && cntWidth'(i) > cnt) begin
          x_mem[fill_sel][i] <= '0;
          w_mem[fill_sel][i] <= '0;
        end
      end
    end
  end

  // Present the selected bank, zero when nothing is full
  always_comb begin
    data_out_x = '0;
    data_out_w = '0;
    bias_out   = '0;
    if (out_valid) begin
      bias_out = bias_mem[pres_sel];
      for (int i = 0; i < size; i++) begin
        data_out_x[bitwidth*i +: bitwidth] = x_mem[pres_sel][i];
        data_out_w[bitwidth*i +: bitwidth] = w_mem[pres_sel][i];
      end
    end
  end

endmodule

// File: tb/tb_axiline_input_loader.sv
// Bench for axiline_input_loader (size=4, bitwidth=8): hand-derived vector
// table, directed multi-cycle sequences and random traffic, all checked
// against a queue-based sample model.
module tb_axiline_input_loader;

  localparam int unsigned BW = 8;
  localparam int unsigned SZ = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned VW = BW * SZ;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last, out_valid, out_ready, err_len;
  logic [BW-1:0] in_x, in_w, in_bias, bias_out;
  logic [VW-1:0] data_out_x, data_out_w;

  axiline_input_loader #(.bitwidth(BW), .size(SZ), .cntWidth(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .in_bias(in_bias), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out_x(data_out_x), .data_out_w(data_out_w),
    .bias_out(bias_out), .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [BW-1:0] x, w, b;
    logic          last, rdy;
    logic          e_rdy, e_val;
    logic [VW-1:0] e_x, e_w;
    logic [BW-1:0] e_b;
    logic          e_err;
  } vec_t;

  typedef struct packed {
    logic [VW-1:0] x;
    logic [VW-1:0] w;
    logic [BW-1:0] b;
  } samp_t;

  // Reference model: completed samples waiting in order, plus one partial sample
  samp_t full_q[$];
  samp_t part;
  int    part_n;
  logic  m_err;

  int n_vec = 0;
  int n_bad = 0;
  int n_pulse;

  function automatic vec_t mk(input logic v, input logic [BW-1:0] x, w, b,
                              input logic last, rdy);
    vec_t t;
    t = '{v: v, x: x, w: w, b: b, last: last, rdy: rdy,
          e_rdy: 1'b0, e_val: 1'b0, e_x: '0, e_w: '0, e_b: '0, e_err: 1'b0};
    return t;
  endfunction

  function automatic vec_t mke(input logic v, input logic [BW-1:0] x, w, b,
                               input logic last, rdy, e_rdy, e_val,
                               input logic [VW-1:0] e_x, e_w,
                               input logic [BW-1:0] e_b, input logic e_err);
    vec_t t;
    t = '{v: v, x: x, w: w, b: b, last: last, rdy: rdy,
          e_rdy: e_rdy, e_val: e_val, e_x: e_x, e_w: e_w, e_b: e_b, e_err: e_err};
    return t;
  endfunction

  task automatic model_reset();
    full_q.delete();
    part   = '0;
    part_n = 0;
    m_err  = 1'b0;
  endtask

  // Drive one cycle, check DUT against model (and table if use_tbl), advance model
  task automatic step(input vec_t t, input bit use_tbl, input logic r, output bit acc);
    logic  m_rdy, m_val;
    samp_t m_s;
    bit    cons, close;
    in_valid  = t.v;   in_x = t.x;  in_w = t.w;  in_bias = t.b;
    in_last   = t.last; out_ready = t.rdy; rst = r;
    #1;
    m_rdy = (full_q.size() < 2);
    m_val = (full_q.size() > 0);
    m_s   = m_val ? full_q[0] : '0;
    n_vec++;
    if (in_ready !== m_rdy || out_valid !== m_val || data_out_x !== m_s.x ||
        data_out_w !== m_s.w || bias_out !== m_s.b || err_len !== m_err) begin
      n_bad++;
      $display("FAIL model vec %0d: got rdy=%b val=%b x=%h w=%h b=%h err=%b, want rdy=%b val=%b x=%h w=%h b=%h err=%b",
               n_vec, in_ready, out_valid, data_out_x, data_out_w, bias_out, err_len,
               m_rdy, m_val, m_s.x, m_s.w, m_s.b, m_err);
    end
    if (use_tbl) begin
      n_vec++;
      if (in_ready !== t.e_rdy || out_valid !== t.e_val || data_out_x !== t.e_x ||
          data_out_w !== t.e_w || bias_out !== t.e_b || err_len !== t.e_err) begin
        n_bad++;
        $display("FAIL table vec %0d: got rdy=%b val=%b x=%h w=%h b=%h err=%b, want rdy=%b val=%b x=%h w=%h b=%h err=%b",
                 n_vec, in_ready, out_valid, data_out_x, data_out_w, bias_out, err_len,
                 t.e_rdy, t.e_val, t.e_x, t.e_w, t.e_b, t.e_err);
      end
    end
    if (out_valid === 1'b1) n_pulse++;
    @(posedge clk);
    acc = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      cons = m_val && t.rdy;
      acc  = t.v && m_rdy;
      if (cons) void'(full_q.pop_front());
      if (acc) begin
        if (part_n == 0) part.b = t.b;
        part.x = part.x | (VW'(t.x) << (BW * part_n));
        part.w = part.w | (VW'(t.w) << (BW * part_n));
        part_n++;
        close = t.last || (part_n == SZ);
        if (close) begin
          if (!t.last) m_err = 1'b1;
          full_q.push_back(part);
          part   = '0;
          part_n = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    bit a;
    for (int i = 0; i < n; i++) step(mk(1'b0, '0, '0, '0, 1'b0, rdy), 1'b0, 1'b0, a);
  endtask

  task automatic do_reset();
    bit a;
    step(mk(1'b0, '0, '0, '0, 1'b0, 1'b0), 1'b0, 1'b1, a);
  endtask

  vec_t tbl[$];

  initial begin
    bit a;
    int idx;

    // Power-up: one unchecked reset edge so DUT and model start together
    in_valid = 0; in_x = 0; in_w = 0; in_bias = 0; in_last = 0; out_ready = 0; rst = 1;
    @(posedge clk); #1;
    model_reset();

    // Table: basic load, second sample in the other bank, short sample over stale data
    tbl.push_back(mke(1, 8'd1,  8'd10, 8'd7, 0, 1, 1, 0, '0, '0, '0, 0));
    tbl.push_back(mke(1, 8'd2,  8'd20, 8'd0, 0, 1, 1, 0, '0, '0, '0, 0));
    tbl.push_back(mke(1, 8'd3,  8'd30, 8'd0, 0, 1, 1, 0, '0, '0, '0, 0));
    tbl.push_back(mke(1, 8'd4,  8'd40, 8'd0, 1, 1, 1, 0, '0, '0, '0, 0));
    tbl.push_back(mke(0, 8'd0,  8'd0,  8'd0, 0, 1, 1, 1, 32'h04030201, 32'h281E140A, 8'd7, 0));
    tbl.push_back(mke(0, 8'd0,  8'd0,  8'd0, 0, 1, 1, 0, '0, '0, '0, 0));
    tbl.push_back(mke(1, 8'h11, 8'h55, 8'd9, 0, 1, 1, 0, '0, '0, '0, 0));
    tbl.push_back(mke(1, 8'h22, 8'h66, 8'd0, 0, 1, 1, 0, '0, '0, '0, 0));
    tbl.push_back(mke(1, 8'h33, 8'h77, 8'd0, 0, 1, 1, 0, '0, '0, '0, 0));
    tbl.push_back(mke(1, 8'h44, 8'h88, 8'd0, 1, 1, 1, 0, '0, '0, '0, 0));
    tbl.push_back(mke(0, 8'd0,  8'd0,  8'd0, 0, 1, 1, 1, 32'h44332211, 32'h88776655, 8'd9, 0));
    tbl.push_back(mke(1, 8'd5,  8'd9,  8'd3, 0, 1, 1, 0, '0, '0, '0, 0));
    tbl.push_back(mke(1, 8'd6,  8'd9,  8'd0, 1, 1, 1, 0, '0, '0, '0, 0));
    tbl.push_back(mke(0, 8'd0,  8'd0,  8'd0, 0, 0, 1, 1, 32'h00000605, 32'h00000909, 8'd3, 0));
    tbl.push_back(mke(0, 8'd0,  8'd0,  8'd0, 0, 1, 1, 1, 32'h00000605, 32'h00000909, 8'd3, 0));
    tbl.push_back(mke(0, 8'd0,  8'd0,  8'd0, 0, 1, 1, 0, '0, '0, '0, 0));
    foreach (tbl[i]) step(tbl[i], 1'b1, 1'b0, a);

    // Full sample into the bank that just held the short one
    for (int k = 0; k < 4; k++)
      step(mk(1, 8'(8'hA0 + k), 8'(8'hB0 + k), 8'h5C, k == 3, 1), 1'b0, 1'b0, a);
    idle(1'b1, 2);

    // Back-pressure: 3 samples with out_ready low, then drain in order
    do_reset();
    idx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step(mk(idx < 12, 8'(idx + 1), 8'(8'h40 + idx), 8'(8'h70 + idx / 4),
              (idx % 4) == 3, cyc >= 10), 1'b0, 1'b0, a);
      if (a) idx++;
    end
    n_vec++;
    if (idx != 12) begin
      n_bad++;
      $display("FAIL backpressure_accepts: got %0d, want 12", idx);
    end

    // Length error: no in_last, then two correct samples; flag stays set
    do_reset();
    for (int k = 0; k < 4; k++) step(mk(1, 8'(k + 1), 8'(k + 2), 8'h33, 0, 1), 1'b0, 1'b0, a);
    for (int k = 0; k < 8; k++)
      step(mk(1, 8'(8'h10 + k), 8'(8'h20 + k), 8'(8'h44 + k / 4), (k % 4) == 3, 1), 1'b0, 1'b0, a);
    idle(1'b1, 3);

    // Reset mid-fill with one full bank pending
    for (int k = 0; k < 6; k++)
      step(mk(1, 8'(8'hC0 + k), 8'(8'hD0 + k), 8'h66, k == 3, 0), 1'b0, 1'b0, a);
    do_reset();
    for (int k = 0; k < 4; k++) step(mk(1, 8'(k + 9), 8'(k + 19), 8'h12, k == 3, 1), 1'b0, 1'b0, a);
    idle(1'b1, 2);

    // Full-rate streaming: 40 elements, 10 one-cycle output pulses
    do_reset();
    n_pulse = 0;
    for (int k = 0; k < 40; k++)
      step(mk(1, 8'(k), 8'(8'hFF - k), 8'(k / 4), (k % 4) == 3, 1), 1'b0, 1'b0, a);
    idle(1'b1, 1);
    n_vec++;
    if (n_pulse != 10) begin
      n_bad++;
      $display("FAIL stream_pulses: got %0d, want 10", n_pulse);
    end

    // Random traffic, occasional reset
    do_reset();
    for (int k = 0; k < 600; k++) begin
      step(mk($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0),
           1'b0, $urandom_range(0, 99) == 0, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
